iter_calculator: RTL and testbench

//   Parametrised, handshaked successor to the fixed-width 8-bit calculator.

---
 rtl/calc_pkg.sv | 15 +
 rtl/calc_iter_core.sv | 73 +++++++
 rtl/iter_calculator.sv | 138 +++++++++++++
 tb/tb_iter_calculator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcode and FSM state encodings for the iterative calculator.
package calc_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } calc_state_e;

endpackage

// File: rtl/calc_iter_core.sv
// One-bit-per-cycle engine shared by shift-add multiply and restoring divide.
// {hi, lo} ends as the product (MUL) or {remainder, quotient} (DIV) after WIDTH steps.
module calc_iter_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic [WIDTH-1:0] m_q;
   logic             div_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH:0]   alu_x;
   logic [WIDTH+1:0] alu_y;

   // DIV trial-subtracts the left-shifted partial remainder; MUL adds the multiplicand to hi.
   // The extra top bit of alu_y is the divide borrow.
   always_comb begin
      alu_x = div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
      if (div_q)
         alu_y = {1'b0, alu_x} - {2'b00, m_q};
      else
         alu_y = {1'b0, alu_x} + {2'b00, m_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         hi_q  <= '0;
         lo_q  <= a;
         m_q   <= b;
         div_q <= is_div;
         cnt_q <= CNT_W'(WIDTH);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
         if (div_q) begin
            if (!alu_y[WIDTH+1]) begin
               hi_q <= alu_y[WIDTH-1:0];
               lo_q <= {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_q <= alu_x[WIDTH-1:0];
               lo_q <= {lo_q[WIDTH-2:0], 1'b0};
            end
         end else if (lo_q[0]) begin
            {hi_q, lo_q} <= {alu_y[WIDTH:0], lo_q[WIDTH-1:1]};
         end else begin
            {hi_q, lo_q} <= {1'b0, hi_q, lo_q[WIDTH-1:1]};
         end
      end
   end

   // busy drops while the final step is being taken, so the owner can leave CALC on that edge.
   assign busy = (cnt_q > CNT_W'(1));
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: rtl/iter_calculator.sv
// Handshaked ADD/SUB/MUL/DIV unit: single-cycle ADD/SUB, iterative MUL/DIV via calc_iter_core.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module iter_calculator
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             zero,
   output logic             div_by_zero,
   output logic [1:0]       state_dbg
);

   calc_state_e      state;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] hi_q;
   logic             carry_q;
   logic             dz_q;
   logic             use_core_q;
   logic             loaded_q;
   logic             accept;
   logic             core_start;
   logic             core_busy;
   logic [WIDTH-1:0] core_hi;
   logic [WIDTH-1:0] core_lo;
   logic [WIDTH:0]   add_sum;

   assign in_ready   = (state == ST_IDLE) && !reset;
   assign accept     = in_valid && in_ready;
   assign core_start = accept && ((op == OP_MUL) || ((op == OP_DIV) && (op_b != '0)));
   assign add_sum    = {1'b0, op_a} + {1'b0, op_b};

   calc_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .reset  (reset),
      .start  (core_start),
      .is_div (op == OP_DIV),
      .a      (op_a),
      .b      (op_b),
      .busy   (core_busy),
      .hi     (core_hi),
      .lo     (core_lo)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         op_q       <= OP_ADD;
         res_q      <= '0;
         hi_q       <= '0;
         carry_q    <= 1'b0;
         dz_q       <= 1'b0;
         use_core_q <= 1'b0;
         loaded_q   <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q       <= op;
                  hi_q       <= '0;
                  carry_q    <= 1'b0;
                  dz_q       <= 1'b0;
                  use_core_q <= 1'b0;
                  case (op)
                     OP_ADD: begin
                        res_q     <= add_sum[WIDTH-1:0];
                        carry_q   <= add_sum[WIDTH];
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        loaded_q  <= 1'b1;
                     end
                     OP_SUB: begin
                        res_q     <= op_a - op_b;
                        carry_q   <= (op_a < op_b);
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        loaded_q  <= 1'b1;
                     end
                     OP_MUL: begin
                        use_core_q <= 1'b1;
                        state      <= ST_CALC;
                     end
                     default: begin
                        if (op_b == '0) begin
                           res_q     <= '1;
                           hi_q      <= op_a;
                           dz_q      <= 1'b1;
                           state     <= ST_DONE;
                           out_valid <= 1'b1;
                           loaded_q  <= 1'b1;
                        end else begin
                           use_core_q <= 1'b1;
                           state      <= ST_CALC;
                        end
                     end
                  endcase
               end
            end
            ST_CALC: begin
               if (!core_busy) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
                  loaded_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // MUL/DIV results live in the core registers, which hold still once the core is idle.
   assign result      = use_core_q ? core_lo : res_q;
   assign result_hi   = use_core_q ? core_hi : hi_q;
   assign carry       = use_core_q ? ((op_q == OP_MUL) && (core_hi != '0)) : carry_q;
   assign zero        = loaded_q && (result == '0);
   assign div_by_zero = dz_q;
   assign state_dbg   = state;

endmodule

// File: tb/tb_iter_calculator.sv
// Self-checking bench for iter_calculator (WIDTH=8): directed cases, backpressure, reset abort, random ops.
module tb_iter_calculator;
   import calc_pkg::*;

   localparam int W     = 8;
   localparam int EXP_W = 2*W + 3 + 8;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   op;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic [W-1:0] result_hi;
   logic         carry;
   logic         zero;
   logic         div_by_zero;
   logic [1:0]   state_dbg;

   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   iter_calculator #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .op          (op),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .result_hi   (result_hi),
      .carry       (carry),
      .zero        (zero),
      .div_by_zero (div_by_zero),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // reference model: {latency, div_by_zero, zero, carry, hi, lo}
   function automatic logic [EXP_W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic [W-1:0]   lo;
      logic [W-1:0]   hi;
      logic           cy;
      logic           dz;
      logic [7:0]     lat;
      logic [W:0]     s;
      logic [2*W-1:0] p;
      hi = '0; lo = '0; cy = 1'b0; dz = 1'b0; lat = 8'd1;
      case (o)
         OP_ADD: begin
            s  = {1'b0, a} + {1'b0, b};
            lo = s[W-1:0];
            cy = s[W];
         end
         OP_SUB: begin
            lo = a - b;
            cy = (a < b);
         end
         OP_MUL: begin
            p   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            lo  = p[W-1:0];
            hi  = p[2*W-1:W];
            cy  = (hi != '0);
            lat = 8'(W + 1);
         end
         default: begin
            if (b == '0) begin
               lo = '1;
               hi = a;
               dz = 1'b1;
            end else begin
               lo  = a / b;
               hi  = a % b;
               lat = 8'(W + 1);
            end
         end
      endcase
      return {lat, dz, (lo == '0), cy, hi, lo};
   endfunction

   task automatic compare_outs(input string tag, input logic [EXP_W-1:0] e);
      check_val({tag, ".result"},      result,      e[W-1:0]);
      check_val({tag, ".result_hi"},   result_hi,   e[2*W-1:W]);
      check_val({tag, ".carry"},       carry,       e[2*W]);
      check_val({tag, ".zero"},        zero,        e[2*W+1]);
      check_val({tag, ".div_by_zero"}, div_by_zero, e[2*W+2]);
   endtask

   // driver: waits for in_ready, presents one command, returns one cycle after acceptance
   task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check_val("in_ready_wait", in_ready, 1);
      in_valid = 1'b1;
      op       = o;
      op_a     = a;
      op_b     = b;
      exp_q.push_back(model(o, a, b));
      @(negedge clk);
      in_valid = 1'b0;
      op       = 2'($urandom_range(0, 3));
      op_a     = W'($urandom_range(0, 255));
      op_b     = W'($urandom_range(0, 255));
   endtask

   // scoreboard side: measures latency, compares, optionally stalls with in_valid pulses
   task automatic receive(input string tag, input int hold);
      logic [EXP_W-1:0] e;
      int lat = 1;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check_val({tag, ".out_valid"}, out_valid, 1);
      check_val({tag, ".sb_depth"}, exp_q.size(), 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_val({tag, ".latency"}, lat, e[EXP_W-1:2*W+3]);
      for (int i = 0; i < hold; i++) begin
         compare_outs({tag, ".hold"}, e);
         check_val({tag, ".hold.in_ready"}, in_ready, 0);
         check_val({tag, ".hold.out_valid"}, out_valid, 1);
         in_valid = ~in_valid;
         op       = OP_ADD;
         @(negedge clk);
      end
      in_valid = 1'b0;
      compare_outs(tag, e);
      check_val({tag, ".busy_in_ready"}, in_ready, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val({tag, ".drop_valid"}, out_valid, 0);
      check_val({tag, ".ready_back"}, in_ready, 1);
      compare_outs({tag, ".idle_keep"}, e);
   endtask

   logic [1:0]   d_op[11] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB, OP_MUL, OP_MUL,
                              OP_DIV, OP_DIV, OP_DIV, OP_DIV};
   logic [W-1:0] d_a[11]  = '{8'd3, 8'd200, 8'd5, 8'd3, 8'd7, 8'd3, 8'd200,
                              8'd10, 8'd200, 8'd10, 8'd200};
   logic [W-1:0] d_b[11]  = '{8'd5, 8'd100, 8'd3, 8'd5, 8'd7, 8'd5, 8'd200,
                              8'd2, 8'd7, 8'd0, 8'd7};
   int           d_hold[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5};

   initial begin
      int seen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op        = OP_ADD;
      op_a      = '0;
      op_b      = '0;
      repeat (3) @(negedge clk);
      check_val("rst.out_valid",   out_valid,   0);
      check_val("rst.in_ready",    in_ready,    0);
      check_val("rst.result",      result,      0);
      check_val("rst.result_hi",   result_hi,   0);
      check_val("rst.carry",       carry,       0);
      check_val("rst.zero",        zero,        0);
      check_val("rst.div_by_zero", div_by_zero, 0);
      check_val("rst.state",       state_dbg,   ST_IDLE);
      reset = 1'b0;
      @(negedge clk);
      check_val("rst.release_ready", in_ready, 1);

      for (int i = 0; i < 11; i++) begin
         send(d_op[i], d_a[i], d_b[i]);
         receive($sformatf("dir%0d", i), d_hold[i]);
      end

      // abort a multiply in its fourth CALC cycle
      send(OP_MUL, 8'd3, 8'd5);
      repeat (3) @(negedge clk);
      check_val("abort.in_calc", state_dbg, ST_CALC);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_val("abort.state",     state_dbg, ST_IDLE);
      check_val("abort.out_valid", out_valid, 0);
      check_val("abort.result",    result,    0);
      check_val("abort.in_ready",  in_ready,  0);
      reset = 1'b0;
      seen  = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check_val("abort.no_valid", seen, 0);
      send(OP_ADD, 8'd3, 8'd5);
      receive("abort.add", 0);

      for (int i = 0; i < 30; i++) begin
         send(2'($urandom_range(0, 3)), W'($urandom_range(0, 255)), W'($urandom_range(0, 15)));
         receive($sformatf("rnd%0d", i), $urandom_range(0, 2));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
